// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the 12-bit 1110_1101_1011 pattern
// transmitter and its matching sequence detector.
package seq_pkg;

  localparam int          WIDTH       = 12;
  localparam logic [11:0] PATTERN_EDB = 12'hEDB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_tx_12_piso.sv
// Loadable parallel-in serial-out shift register; the MSB is the serial output.
// Zero-fill on shift so the output drops to 0 once the word is exhausted.
module seq_piso #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] load_dat_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clear_i)      sr_d = '0;
    else if (load_i)  sr_d = load_dat_i;
    else if (shift_i) sr_d = {sr_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_tx_12.sv
// Burst transmitter of PATTERN (MSB first) for reps repetitions with optional
// idle gaps; all outputs are flops computed from the next state.
module seq_tx_12 #(
  parameter int               WIDTH   = seq_pkg::WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = seq_pkg::PATTERN_EDB,
  parameter int               REP_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [REP_W-1:0] reps_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             abort_i,
  output logic             x_o,
  output logic             valid_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic             done_o
);
  import seq_pkg::*;

  localparam int               BIT_W   = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             piso_load, piso_shift, piso_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    gap_d      = gap_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    // abort beats start in IDLE and beats everything in the other states
    if (state_q != IDLE && abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i && !abort_i) begin
          if (reps_i == '0) begin
            state_d = FIN;
          end else begin
            state_d   = SEND;
            bit_cnt_d = BIT_MAX;
            rep_cnt_d = reps_i;
            gap_d     = gap_i;
            piso_load = 1'b1;
          end
        end
        SEND: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d  = bit_cnt_q - 1'b1;
            piso_shift = 1'b1;
          end else if (rep_cnt_q > REP_W'(1)) begin
            rep_cnt_d = rep_cnt_q - 1'b1;
            bit_cnt_d = BIT_MAX;
            if (gap_q == '0) begin
              piso_load = 1'b1;
            end else begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            state_d   = IDLE;
            rep_cnt_d = '0;
          end
        end
        GAP: begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          if (gap_cnt_q == GAP_W'(1)) begin
            state_d   = SEND;
            piso_load = 1'b1;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs describe the cycle the FSM is about to enter.
  always_comb begin
    valid_d    = (state_d == SEND);
    frame_d    = valid_d && (bit_cnt_d == BIT_MAX);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN) ||
                 (valid_d && bit_cnt_d == '0 && rep_cnt_d == REP_W'(1));
    piso_clear = !valid_d;
  end

  seq_piso #(.WIDTH(WIDTH)) u_piso (
    .clk        (clk),
    .reset      (reset),
    .load_i     (piso_load),
    .shift_i    (piso_shift),
    .clear_i    (piso_clear),
    .load_dat_i (PATTERN),
    .msb_o      (x_o)
  );

  assign valid_o = valid_q;
  assign frame_o = frame_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
